audio_linear_interp: RTL and testbench

//  Stereo upsampler feeding the sigma-delta DAC stage. Accepts signed 16-bit
//  L/R samples at audio rate over a valid/ready handshake and, every Clk,

---
 rtl/audio_linear_interp.sv | 138 +++++++++++++
 tb/tb_audio_linear_interp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/audio_linear_interp.sv
// Stereo first-order-hold upsampler: each accepted L/R sample becomes the end point
// of a 2**STEP_LOG2-clock linear ramp that starts from the previous end point.
module audio_linear_interp #(
  parameter int STEP_LOG2 = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        underrun
);
  localparam int AW = 17 + STEP_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [STEP_LOG2-1:0] count_q, count_d;
  logic                 pend_full_q, pend_full_d;
  logic [15:0]          pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [15:0]          target_l_q, target_l_d, target_r_q, target_r_d;
  logic [16:0]          delta_l_q, delta_l_d, delta_r_q, delta_r_d;
  logic [AW-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic                 underrun_q, underrun_d;
  logic                 accept, ramp_end, load;
  logic [15:0]          start_l, start_r;

  // Sign-extend a 16-bit sample and place it at the integer position of acc.
  function automatic logic [AW-1:0] scale(input logic [15:0] v);
    return {{(STEP_LOG2 + 1){v[15]}}, v} << STEP_LOG2;
  endfunction

  function automatic logic [AW-1:0] sext_delta(input logic [16:0] d);
    return {{STEP_LOG2{d[16]}}, d};
  endfunction

  // Handshake: a transfer happens on any edge where in_valid && in_ready;
  // in_ready is low while the one-entry pending buffer is full or Reset is high.
  assign in_ready = !pend_full_q && !Reset;
  assign accept   = in_valid && in_ready;
  assign ramp_end = (state_q == RAMP) && (count_q == '1);
  // Only a sample already pending before the edge can start the next ramp.
  assign load     = pend_full_q && ((state_q != RAMP) || ramp_end);
  assign start_l  = (state_q == IDLE) ? 16'h0000 : target_l_q;
  assign start_r  = (state_q == IDLE) ? 16'h0000 : target_r_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    target_l_d  = target_l_q;
    target_r_d  = target_r_q;
    delta_l_d   = delta_l_q;
    delta_r_d   = delta_r_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    underrun_d  = 1'b0;

    if (accept) begin
      pend_full_d = 1'b1;
      pend_l_d    = in_l;
      pend_r_d    = in_r;
    end

    if (state_q == RAMP) begin
      if (ramp_end) begin
        // Snap to the exact end point so truncation error never accumulates.
        acc_l_d = scale(target_l_q);
        acc_r_d = scale(target_r_q);
        if (!pend_full_q) begin
          state_d    = HOLD;
          underrun_d = 1'b1;
        end
      end else begin
        acc_l_d = acc_l_q + sext_delta(delta_l_q);
        acc_r_d = acc_r_q + sext_delta(delta_r_q);
        count_d = count_q + STEP_LOG2'(1);
      end
    end

    if (load) begin
      target_l_d  = pend_l_q;
      target_r_d  = pend_r_q;
      delta_l_d   = {pend_l_q[15], pend_l_q} - {start_l[15], start_l};
      delta_r_d   = {pend_r_q[15], pend_r_q} - {start_r[15], start_r};
      acc_l_d     = scale(start_l);
      acc_r_d     = scale(start_r);
      count_d     = '0;
      pend_full_d = 1'b0;
      state_d     = RAMP;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      target_l_q  <= '0;
      target_r_q  <= '0;
      delta_l_q   <= '0;
      delta_r_q   <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pend_full_q <= pend_full_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      target_l_q  <= target_l_d;
      target_r_q  <= target_r_d;
      delta_l_q   <= delta_l_d;
      delta_r_q   <= delta_r_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      underrun_q  <= underrun_d;
    end
  end

  // acc is a flop, so the integer slice is a registered output (floor rounding).
  assign out_l    = acc_l_q[STEP_LOG2+15:STEP_LOG2];
  assign out_r    = acc_r_q[STEP_LOG2+15:STEP_LOG2];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_linear_interp.sv
// Directed bench for audio_linear_interp: a STEP_LOG2=2 instance for most scenarios
// and a STEP_LOG2=8 instance for the full-scale swing.
module tb_audio_linear_interp;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, underrun;
  logic [15:0] in_l = '0, in_r = '0, out_l, out_r;
  logic        in_valid8 = 1'b0, in_ready8, underrun8;
  logic [15:0] in_l8 = '0, in_r8 = '0, out_l8, out_r8;
  int          total = 0;
  int          bad = 0;

  always #5 Clk = ~Clk;

  audio_linear_interp #(.STEP_LOG2(2)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .out_l(out_l), .out_r(out_r), .underrun(underrun)
  );

  audio_linear_interp #(.STEP_LOG2(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_l(in_l8), .in_r(in_r8), .out_l(out_l8), .out_r(out_r8), .underrun(underrun8)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
      total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL reset_out: got %h/%h want 0/0", out_l, out_r); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    end
    Reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL idle_underrun: got %b want 0", underrun); end
      total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL idle_out: got %h/%h want 0/0", out_l, out_r); end
    end
  endtask

  task automatic test_single();
    logic [15:0] el, er;
    in_l = 16'h0400; in_r = 16'hFC00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %b want 0", in_ready); end
    tick();
    total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL single_load: got %h/%h want 0/0", out_l, out_r); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      el = 16'(k * 256);
      er = 16'(-k * 256);
      total++; if (out_l !== el) begin bad++; $display("FAIL single_out_l step %0d: got %h want %h", k, out_l, el); end
      total++; if (out_r !== er) begin bad++; $display("FAIL single_out_r step %0d: got %h want %h", k, out_r, er); end
      total++; if (underrun !== (k == 4)) begin bad++; $display("FAIL single_underrun step %0d: got %b want %b", k, underrun, k == 4); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({out_l, out_r} !== 32'h0400FC00) begin bad++; $display("FAIL single_hold: got %h/%h want 0400/fc00", out_l, out_r); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL single_pulse_len: got %b want 0", underrun); end
    end
  endtask

  task automatic test_stream();
    int n;
    logic exp_rdy, took;
    logic [15:0] el, er;
    do_reset(2);
    n = 0;
    in_valid = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      in_l = 16'(n * 4096);
      in_r = 16'(-n * 4096);
      exp_rdy = (c == 0) || (c >= 2 && ((c - 2) % 4) == 0);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL stream_ready cyc %0d: got %b want %b", c, in_ready, exp_rdy); end
      took = in_ready;
      tick();
      if (took) n++;
      el = (c >= 5) ? 16'((c - 5) * 1024) : 16'h0000;
      er = (c >= 5) ? 16'(-(c - 5) * 1024) : 16'h0000;
      total++; if (out_l !== el) begin bad++; $display("FAIL stream_out_l cyc %0d: got %h want %h", c, out_l, el); end
      total++; if (out_r !== er) begin bad++; $display("FAIL stream_out_r cyc %0d: got %h want %h", c, out_r, er); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun cyc %0d: got %b want 0", c, underrun); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_scale();
    int a, b, prev_l, prev_r;
    logic [15:0] el, er;
    do_reset(2);
    in_l8 = 16'h8000; in_r8 = 16'h7FFF; in_valid8 = 1'b1;
    tick();
    in_l8 = 16'h7FFF; in_r8 = 16'h8000;
    tick();
    tick();
    in_valid8 = 1'b0;
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL full_pending: got %b want 0", in_ready8); end
    repeat (255) begin
      tick();
      total++; if (underrun8 !== 1'b0) begin bad++; $display("FAIL full_first_underrun: got %b want 0", underrun8); end
    end
    total++; if ({out_l8, out_r8} !== 32'h80007FFF) begin bad++; $display("FAIL full_first_end: got %h/%h want 8000/7fff", out_l8, out_r8); end
    prev_l = -32768;
    prev_r = 32767;
    for (int k = 1; k <= 256; k++) begin
      tick();
      a = -8388608 + k * 65535;
      b = 8388352 - k * 65535;
      el = 16'(a >>> 8);
      er = 16'(b >>> 8);
      total++; if (out_l8 !== el) begin bad++; $display("FAIL full_out_l step %0d: got %h want %h", k, out_l8, el); end
      total++; if (out_r8 !== er) begin bad++; $display("FAIL full_out_r step %0d: got %h want %h", k, out_r8, er); end
      total++; if (int'($signed(out_l8)) < prev_l) begin bad++; $display("FAIL full_mono_l step %0d: got %0d want >= %0d", k, $signed(out_l8), prev_l); end
      total++; if (underrun8 !== (k == 256)) begin bad++; $display("FAIL full_underrun step %0d: got %b want %b", k, underrun8, k == 256); end
      prev_l = int'($signed(out_l8));
      prev_r = int'($signed(out_r8));
    end
    total++; if (prev_r !== -32768) begin bad++; $display("FAIL full_final_r: got %0d want -32768", prev_r); end
  endtask

  task automatic test_floor();
    do_reset(2);
    in_l = 16'hFFFF; in_r = 16'h0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL floor_load: got %h/%h want 0/0", out_l, out_r); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (out_l !== 16'hFFFF) begin bad++; $display("FAIL floor_neg step %0d: got %h want ffff", k, out_l); end
      total++; if (out_r !== ((k == 4) ? 16'h0001 : 16'h0000)) begin bad++; $display("FAIL floor_pos step %0d: got %h want %h", k, out_r, (k == 4) ? 16'h0001 : 16'h0000); end
      total++; if (underrun !== (k == 4)) begin bad++; $display("FAIL floor_underrun step %0d: got %b want %b", k, underrun, k == 4); end
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset(2);
    in_l = 16'h0800; in_r = 16'hF800; in_valid = 1'b1;
    tick();
    in_l = 16'h7000; in_r = 16'h7000;
    tick();
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_pending: got %b want 0", in_ready); end
    total++; if ({out_l, out_r} !== 32'h0200FE00) begin bad++; $display("FAIL mid_step1: got %h/%h want 0200/fe00", out_l, out_r); end
    tick();
    total++; if ({out_l, out_r} !== 32'h0400FC00) begin bad++; $display("FAIL mid_step2: got %h/%h want 0400/fc00", out_l, out_r); end
    Reset = 1'b1;
    tick();
    total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL mid_reset_out: got %h/%h want 0/0", out_l, out_r); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL mid_reset_underrun: got %b want 0", underrun); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_dropped_ready: got %b want 1", in_ready); end
      tick();
      total++; if ({out_l, out_r} !== 32'h0) begin bad++; $display("FAIL mid_idle_out: got %h/%h want 0/0", out_l, out_r); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL mid_idle_underrun: got %b want 0", underrun); end
    end
    in_l = 16'h0400; in_r = 16'hFC00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (out_l !== 16'(k * 256)) begin bad++; $display("FAIL mid_new_ramp step %0d: got %h want %h", k, out_l, 16'(k * 256)); end
      total++; if (underrun !== (k == 4)) begin bad++; $display("FAIL mid_new_underrun step %0d: got %b want %b", k, underrun, k == 4); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_full_scale();
    test_floor();
    test_reset_mid_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
